// File: rtl/line_feeder_pkg.sv
// line_feeder_pkg
//   Shared types and defaults for the projection line feeder.
//   - lf_state_e    : feeder FSM states
//   - LF_*          : default sample width, line length and flush length
//   - cnt_width()   : bits needed to hold 0..max_cnt (never below 1)
package line_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    FEED  = 2'd2,
    FLUSH = 2'd3
  } lf_state_e;

  localparam int unsigned LF_DATA_LEN  = 12;
  localparam int unsigned LF_LINE_SIZE = 256;
  // Flush length is tap spacing times number of taps.
  localparam int unsigned LF_FLUSH_LEN = 240;

  // A zero flush length would give a zero-width counter; keep one bit.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt == 0) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/line_feeder_if.sv
// line_feeder_if
//   Handshake and line-buffer bus of the feeder.
//   master: drives start/hold/in_valid/in_data, observes the rest.
//   slave : the feeder itself.
//   DW    : sample width.
interface line_feeder_if #(
  parameter int unsigned DW = 12
);
  logic          start;
  logic          hold;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          lb_clear;
  logic          lb_enable;
  logic [DW-1:0] lb_shift_in;
  logic          busy;
  logic          done;

  modport master (
    output start, hold, in_valid, in_data,
    input  in_ready, lb_clear, lb_enable, lb_shift_in, busy, done
  );

  modport slave (
    input  start, hold, in_valid, in_data,
    output in_ready, lb_clear, lb_enable, lb_shift_in, busy, done
  );
endinterface

// File: rtl/line_feeder_counter.sv
// feeder_counter
//   Up-counter with synchronous clear and enable, saturating at MAX.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (wins over en)
//   en       : count one event
//   last     : count is MAX-1, i.e. the next enabled event is the MAX-th
module feeder_counter #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam logic [W-1:0] LAST_V = W'((MAX > 0) ? MAX - 1 : 0);
  localparam logic [W-1:0] MAX_V  = W'(MAX);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (en && cnt_q != MAX_V)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // MAX==0 never has a last event; the FSM bypasses that counter.
  assign last = (MAX > 0) && (cnt_q == LAST_V);
endmodule

// File: rtl/line_feeder.sv
// line_feeder
//   Streams one filtered projection line into a shift-register line buffer,
//   then pushes pFlushLength zeros so the taps drain.
//   Ports:
//     clk          : clock, rising edge
//     clear        : synchronous active-high reset, overrides everything
//     bus (slave)  : start/hold/in_valid/in_data in; in_ready (comb),
//                    lb_clear/lb_enable/lb_shift_in/busy/done (registered)
//     underrun_cnt : FEED cycles starved of input, saturating
//                    (only with LINE_FEEDER_UNDERRUN_CNT_EN defined)
//   Config macro: LINE_FEEDER_UNDERRUN_CNT_EN
module line_feeder
  import line_feeder_pkg::*;
#(
  parameter int unsigned pDataLength  = LF_DATA_LEN,
  parameter int unsigned pLineSize    = LF_LINE_SIZE,
  parameter int unsigned pFlushLength = LF_FLUSH_LEN
) (
  input  logic        clk,
  input  logic        clear,
  line_feeder_if.slave bus
`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);
  localparam int unsigned SW = cnt_width(pLineSize);
  localparam int unsigned FW = cnt_width(pFlushLength);

  lf_state_e              state_d, state_q;
  logic                   lb_clear_d, lb_clear_q;
  logic                   lb_enable_d, lb_enable_q;
  logic [pDataLength-1:0] lb_shift_in_d, lb_shift_in_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;

  logic in_ready, accept, flush_shift, line_start;
  logic sample_last, flush_last;

  assign in_ready    = (state_q == FEED) && !bus.hold;
  assign accept      = bus.in_valid && in_ready;
  assign flush_shift = (state_q == FLUSH) && !bus.hold;
  assign line_start  = (state_q == IDLE) && bus.start;

  feeder_counter #(.MAX(pLineSize), .W(SW)) u_sample_cnt (
    .clk (clk), .rst (clear), .clr (line_start), .en (accept), .last (sample_last)
  );

  feeder_counter #(.MAX(pFlushLength), .W(FW)) u_flush_cnt (
    .clk (clk), .rst (clear), .clr (line_start), .en (flush_shift), .last (flush_last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = CLR;
      CLR:  state_d = FEED;
      FEED: if (accept && sample_last) begin
        // No flush configured: the last sample closes the line.
        if (pFlushLength == 0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH: if (flush_shift && flush_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    lb_clear_d    = line_start;
    lb_enable_d   = accept || flush_shift;
    lb_shift_in_d = accept ? bus.in_data : '0;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      lb_clear_q    <= 1'b0;
      lb_enable_q   <= 1'b0;
      lb_shift_in_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lb_clear_q    <= lb_clear_d;
      lb_enable_q   <= lb_enable_d;
      lb_shift_in_q <= lb_shift_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.lb_clear    = lb_clear_q;
  assign bus.lb_enable   = lb_enable_q;
  assign bus.lb_shift_in = lb_shift_in_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_d, underrun_q;

  always_comb begin
    underrun_d = underrun_q;
    if (line_start)
      underrun_d = '0;
    else if ((state_q == FEED) && !bus.hold && !bus.in_valid && (underrun_q != 16'hFFFF))
      underrun_d = underrun_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (clear) underrun_q <= '0;
    else       underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`endif
endmodule

// File: tb/tb_line_feeder.sv
`timescale 1ns/1ps
module tb_line_feeder;
  localparam int DW = 12;
  localparam int LS = 8;
  localparam int FL = 6;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  line_feeder_if #(.DW(DW)) bus ();
  line_feeder_if #(.DW(DW)) bus0 ();

  // Second feeder with no flush phase shares the same stimulus.
  assign bus0.start    = bus.start;
  assign bus0.hold     = bus.hold;
  assign bus0.in_valid = bus.in_valid;
  assign bus0.in_data  = bus.in_data;

`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] urc, urc0;
`endif

  line_feeder #(.pDataLength(DW), .pLineSize(LS), .pFlushLength(FL)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
    , .underrun_cnt (urc)
`endif
  );

  line_feeder #(.pDataLength(DW), .pLineSize(LS), .pFlushLength(0)) u_nf (
    .clk   (clk),
    .clear (clear),
    .bus   (bus0)
`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
    , .underrun_cnt (urc0)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-line observations
  int en_cnt, clr_cnt, done_cnt, done_at, rdy_cnt, bad_zero;
  int done_en, done_busy, done_sh;
  int nf_en, nf_done_at, nf_done_en, nf_last;
  int post_clr;
  logic [DW-1:0] shifts[$];

  // Runs one line from a start pulse. hold_nxt/gap_nxt: sample number at
  // which a 3-cycle hold / 2-cycle valid gap begins (0 = none).
  // restart_at/clr_at: loop cycle of a stray start / a clear (-1 = none).
  task automatic run_line(input int hold_nxt, input int gap_nxt,
                          input int restart_at, input int clr_at,
                          input int max_cyc, input bit stop_on_done);
    int nxt, hold_left, gap_left;
    bit hold_used, gap_used, rdy, acc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    shifts.delete();
    en_cnt = 0; done_cnt = 0; done_at = -1; rdy_cnt = 0; bad_zero = 0;
    done_en = -1; done_busy = -1; done_sh = -1; post_clr = -1;
    nf_en = 0; nf_done_at = -1; nf_done_en = -1; nf_last = -1;
    clr_cnt = int'(bus.lb_clear);
    nxt = 1; hold_left = 0; gap_left = 0; hold_used = 0; gap_used = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!hold_used && nxt == hold_nxt) begin hold_used = 1; hold_left = 3; end
      if (!gap_used && nxt == gap_nxt) begin gap_used = 1; gap_left = 2; end
      bus.hold     = (hold_left > 0);
      bus.in_valid = (nxt <= LS) && (gap_left == 0);
      bus.in_data  = DW'(nxt);
      bus.start    = (c == restart_at);
      clear        = (c == clr_at);
      #1;
      rdy = bus.in_ready;
      acc = rdy && bus.in_valid;
      if (rdy) rdy_cnt++;
      tick();
      if (acc) nxt++;
      if (hold_left > 0) hold_left--;
      if (gap_left > 0) gap_left--;
      if (bus.lb_enable) begin en_cnt++; shifts.push_back(bus.lb_shift_in); end
      else if (bus.lb_shift_in != '0) bad_zero++;
      if (bus.lb_clear) clr_cnt++;
      if (bus0.lb_enable) begin nf_en++; nf_last = int'(bus0.lb_shift_in); end
      if (bus0.done && nf_done_at < 0) begin nf_done_at = c + 1; nf_done_en = int'(bus0.lb_enable); end
      if (c == clr_at)
        post_clr = int'({bus.lb_clear, bus.lb_enable, bus.busy, bus.done, bus.lb_shift_in});
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c + 1; done_en = int'(bus.lb_enable);
          done_busy = int'(bus.busy); done_sh = int'(bus.lb_shift_in);
        end
        if (stop_on_done) break;
      end
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.hold = 1'b0; clear = 1'b0;
  endtask

  task automatic check_line(input string nm, input int exp_done, input int exp_rdy);
    chk({nm, "_en_cnt"}, en_cnt, LS + FL);
    chk({nm, "_lb_clear_cnt"}, clr_cnt, 1);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_done_at"}, done_at, exp_done);
    chk({nm, "_done_with_en"}, done_en, 1);
    chk({nm, "_done_shift"}, done_sh, 0);
    chk({nm, "_busy_at_done"}, done_busy, 0);
    chk({nm, "_idle_shift_zero"}, bad_zero, 0);
    chk({nm, "_rdy_cnt"}, rdy_cnt, exp_rdy);
    for (int i = 0; i < LS + FL; i++)
      chk($sformatf("%s_sh%0d", nm, i),
          (i < shifts.size()) ? 32'(shifts[i]) : 32'hFFFF_FFFF,
          (i < LS) ? i + 1 : 0);
  endtask

  initial begin
    bus.start = 0; bus.hold = 0; bus.in_valid = 0; bus.in_data = '0;
    clear = 1'b1;
    tick(); tick();
    chk("rst_lb_clear", bus.lb_clear, 0);
    chk("rst_lb_enable", bus.lb_enable, 0);
    chk("rst_shift", bus.lb_shift_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    clear = 1'b0;
    tick();

    // continuous valid, no stalls
    run_line(0, 0, -1, -1, 40, 1);
    check_line("t1", 15, 8);
    chk("nf_en_cnt", nf_en, LS);
    chk("nf_done_at", nf_done_at, 9);
    chk("nf_done_with_en", nf_done_en, 1);
    chk("nf_last_shift", nf_last, LS);
`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
    chk("t1_underrun", urc, 0);
`endif
    tick();
    chk("t1_busy_after", bus.busy, 0);

    // 3-cycle hold at sample 4
    run_line(4, 0, -1, -1, 40, 1);
    check_line("hold", 18, 8);
`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
    chk("hold_underrun", urc, 0);
`endif
    tick();

    // 2-cycle valid gap after sample 5
    run_line(0, 6, -1, -1, 40, 1);
    check_line("gap", 17, 10);
`ifdef LINE_FEEDER_UNDERRUN_CNT_EN
    chk("gap_underrun", urc, 2);
`endif
    tick();

    // clear during the third flush shift
    run_line(0, 0, -1, 11, 25, 0);
    chk("clr_post_outputs", post_clr, 0);
    chk("clr_no_done", done_cnt, 0);
    chk("clr_en_cnt", en_cnt, 10);
    chk("clr_busy_end", bus.busy, 0);
    tick();

    // start together with clear in IDLE is ignored
    bus.start = 1'b1; clear = 1'b1;
    tick();
    bus.start = 1'b0; clear = 1'b0;
    chk("stclr_lb_clear", bus.lb_clear, 0);
    chk("stclr_busy", bus.busy, 0);
    tick();
    chk("stclr_still_idle", bus.busy, 0);

    // stray start in FEED ignored; start in the done cycle accepted
    run_line(0, 0, 4, -1, 40, 1);
    check_line("restart", 15, 8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("done_start_lb_clear", bus.lb_clear, 1);
    chk("done_start_busy", bus.busy, 1);
    tick();
    chk("done_start_clear_1cyc", bus.lb_clear, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("final_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
